// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-store buffer: entry layout, port-grant encoding
// and the occupancy-counter width helper.
package store_buffer_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_LOAD,
    GNT_DRAIN
  } sb_grant_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the pending store entries, walking from head
// (oldest) towards tail so that the last hit seen is the youngest.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  sb_entry_t                  entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic                       hit_o,
  output logic [$clog2(DEPTH)-1:0]   hit_idx_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] slot;
  logic             unused_data;

  always_comb begin
    hit_o       = 1'b0;
    hit_idx_o   = '0;
    slot        = '0;
    unused_data = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      unused_data = unused_data ^ (^entries_i[k].data);
      slot = PTR_W'(head_i + k);
      if (CNT_W'(k) < count_i && entries_i[slot].addr == ld_addr_i) begin
        hit_o     = 1'b1;
        hit_idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of data_memory with load/drain port arbitration.
// STORE_BUFFER_FWD_EN: forward youngest pending store to loads; otherwise stall on match.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = store_buffer_pkg::ADDR_W,
  parameter int unsigned DATA_W = store_buffer_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [DATA_W-1:0]       st_data,
  output logic                    st_ready,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_addr,
  output logic [DATA_W-1:0]       ld_data,
  output logic                    ld_stall,
  input  logic                    fence,
  output logic                    fence_busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [DATA_W-1:0]       mem_read_data
);

  import store_buffer_pkg::*;

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  sb_grant_e        grant;
  logic             full, enq, deq, hit, load_blocked;
  logic [PTR_W-1:0] hit_idx;

  store_buffer_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .ld_addr_i (ld_addr),
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
  );

`ifdef STORE_BUFFER_FWD_EN
  assign load_blocked = 1'b0;
`else
  logic unused_hit_idx;
  assign load_blocked   = hit;
  assign unused_hit_idx = ^hit_idx;
`endif

  assign full       = (count_q == FULL_CNT);
  assign st_ready   = !reset && !full;
  assign enq        = st_valid && st_ready;
  assign deq        = (grant == GNT_DRAIN);
  assign fence_busy = !reset && fence && (count_q != '0);
  assign count      = reset ? '0 : count_q;

  // A full buffer or a blocked load both hand the port to the drain, so stores
  // keep retiring even under a continuous load stream.
  always_comb begin
    grant    = GNT_NONE;
    ld_stall = 1'b0;
    if (!reset) begin
      if (ld_valid && (full || load_blocked)) begin
        grant    = GNT_DRAIN;
        ld_stall = 1'b1;
      end else if (ld_valid) begin
        grant = GNT_LOAD;
      end else if (count_q != '0) begin
        grant = GNT_DRAIN;
      end
    end
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    ld_data        = '0;
    case (grant)
      GNT_LOAD: begin
        mem_read    = 1'b1;
        mem_address = ld_addr;
`ifdef STORE_BUFFER_FWD_EN
        ld_data     = hit ? entries_q[hit_idx].data : mem_read_data;
`else
        ld_data     = mem_read_data;
`endif
      end
      GNT_DRAIN: begin
        mem_write      = 1'b1;
        mem_address    = entries_q[head_q].addr;
        mem_write_data = entries_q[head_q].data;
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = deq ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q] <= sb_entry_t'{addr: st_addr, data: st_data};
    end
  end

endmodule
